alu_tile_host_port: RTL

- Host-side stage directly upstream and downstream of an ALU NoC tile's host port.
- Accepts host commands (a, b, ctrl) on a valid/ready interface, queues them, and drives the tile's host_in_* inputs as single-cycle valid pulses.
- Captures the tile's host_out_a/host_out_valid results, which carry no backpressure, into a response queue drained on a valid/ready interface.
- Issue is credit-limited so no tile result is ever dropped; a watchdog recovers from lost results.

---
 rtl/alu_noc_pkg.sv | 25 ++
 rtl/alu_sync_fifo.sv | 55 +++++
 rtl/alu_tile_host_port.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_noc_pkg.sv
// alu_noc_pkg: shared widths, bundles and watchdog states
// for the ALU tile host port.
package alu_noc_pkg;

  localparam int ALU_DATA_W = 64;
  localparam int ALU_CTRL_W = 16;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_CTRL_W-1:0] ctrl;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic                  timeout;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_WAIT,
    WD_EXPIRE
  } wd_state_e;

endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: in-order synchronous FIFO, power-of-2 depth,
// head word visible combinationally on rdata.
module alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_tile_host_port.sv
// alu_tile_host_port: credit-limited host stage for an ALU tile.
// Optional watchdog: define ALU_HOST_PORT_TIMEOUT_EN.
module alu_tile_host_port
  import alu_noc_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int CTRL_W      = ALU_CTRL_W,
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  input  logic [CTRL_W-1:0]          cmd_ctrl,
  output logic [DATA_W-1:0]          tile_in_a,
  output logic [DATA_W-1:0]          tile_in_b,
  output logic [CTRL_W-1:0]          tile_in_ctrl,
  output logic                       tile_in_valid,
  input  logic [DATA_W-1:0]          tile_out_a,
  input  logic                       tile_out_valid,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_timeout,
  output logic [$clog2(MAX_OUT):0]   inflight,
  output logic                       err_unexpected
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUT);

  alu_cmd_t cmd_in, cmd_head, issue_cmd;
  alu_rsp_t rsp_in, rsp_head;

  logic                       cmd_full, cmd_empty;
  logic                       cmd_fire, cmd_push, cmd_pop;
  logic [$clog2(CMD_DEPTH):0] unused_cmd_cnt;
  logic                       rsp_full, rsp_empty;
  logic                       rsp_push, rsp_pop;
  logic [CW-1:0]              rsp_cnt;
  logic [CW:0]                used;
  logic                       has_credit, issue, bypass;
  logic                       capture, expire, retire;
  logic [CW-1:0]              inflight_nx;

  assign cmd_in     = '{a: cmd_a, b: cmd_b, ctrl: cmd_ctrl};
  assign cmd_ready  = !cmd_full;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign used       = {1'b0, inflight} + {1'b0, rsp_cnt};
  assign has_credit = (used < MAX_C);
  assign issue      = has_credit && (!cmd_empty || cmd_fire);
  assign bypass     = cmd_empty && cmd_fire && has_credit;
  assign issue_cmd  = cmd_empty ? cmd_in : cmd_head;
  assign cmd_push   = cmd_fire && !bypass;
  assign cmd_pop    = issue && !cmd_empty;

  assign capture  = tile_out_valid && (inflight != '0);
  assign retire   = capture || expire;
  assign rsp_push = retire;
  assign rsp_pop  = rsp_valid && rsp_ready;

  assign rsp_valid   = !rsp_empty;
  assign rsp_data    = rsp_valid ? rsp_head.data : '0;
  assign rsp_timeout = rsp_valid && rsp_head.timeout;

  alu_sync_fifo #(
    .WIDTH ($bits(alu_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (unused_cmd_cnt)
  );

  alu_sync_fifo #(
    .WIDTH ($bits(alu_rsp_t)),
    .DEPTH (MAX_OUT)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_cnt)
  );

  // response word: tile result, else a timeout word
  always_comb begin
    rsp_in = '{data: '0, timeout: 1'b1};
    if (capture) rsp_in = '{data: tile_out_a, timeout: 1'b0};
  end

  // next in-flight count
  always_comb begin
    inflight_nx = inflight;
    case ({issue, retire})
      2'b10:   inflight_nx = inflight + CW'(1);
      2'b01:   inflight_nx = inflight - CW'(1);
      default: inflight_nx = inflight;
    endcase
  end

  // issue register, credit count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_in_valid  <= 1'b0;
      tile_in_a      <= '0;
      tile_in_b      <= '0;
      tile_in_ctrl   <= '0;
      inflight       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      tile_in_valid <= issue;
      if (issue) begin
        tile_in_a    <= issue_cmd.a;
        tile_in_b    <= issue_cmd.b;
        tile_in_ctrl <= issue_cmd.ctrl;
      end
      inflight <= inflight_nx;
      if (tile_out_valid && inflight == '0)
        err_unexpected <= 1'b1;
    end
  end

`ifdef ALU_HOST_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  wd_state_e     wd_q, wd_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;

  assign expire = (wd_q == WD_WAIT) && !capture &&
                  (wd_cnt_q == T_LAST);

  // watchdog state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
    end else begin
      wd_q     <= wd_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // watchdog next state; expiry pushes on entry to EXPIRE
  always_comb begin
    wd_d     = wd_q;
    wd_cnt_d = '0;
    unique case (wd_q)
      WD_IDLE: begin
        if (issue) wd_d = WD_WAIT;
      end
      WD_WAIT: begin
        if (expire) begin
          wd_d = WD_EXPIRE;
        end else begin
          if (!capture) wd_cnt_d = wd_cnt_q + TW'(1);
          if (inflight_nx == '0) wd_d = WD_IDLE;
        end
      end
      WD_EXPIRE: begin
        wd_d = (inflight_nx != '0) ? WD_WAIT : WD_IDLE;
      end
      default: wd_d = WD_IDLE;
    endcase
  end
`else
  logic unused_wd;
  assign expire    = 1'b0;
  assign unused_wd = (TIMEOUT_CYC == 0);
`endif

endmodule
